// File: rtl/stream_mux_rr_if.sv
// Bundle of the N input streams and the single registered output stream of stream_mux_rr.
// slave is the multiplexer's view; master is the producer/consumer side that drives it.
interface stream_mux_rr_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_last;
  logic [SW-1:0]      out_sel;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_sel
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_sel
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready/last stream multiplexer with round-robin arbitration,
// optional per-packet grant locking and a single registered output slot.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int N        = 4,
  parameter bit LOCK_PKT = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_rr_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_r, state_nx_s;
  logic [SW-1:0]    ptr_r, ptr_nx_s;
  logic [SW-1:0]    lock_ch_r, lock_ch_nx_s;
  logic [SW-1:0]    cand_s, gidx_s;
  logic             gvalid_s;
  logic [N-1:0]     grant_s;
  logic             load_en_s, xfer_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             sel_last_s;

  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r, out_last_r;
  logic [SW-1:0]    out_sel_r;

  // Slot accepts a new beat when empty or draining; rst_n keeps in_ready low during reset.
  assign load_en_s    = rst_n & (~out_valid_r | bus.out_ready);
  assign grant_s      = gvalid_s ? (ONE_HOT0 << gidx_s) : {N{1'b0}};
  assign bus.in_ready = grant_s & {N{load_en_s}};
  assign xfer_s       = gvalid_s & load_en_s;

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_sel   = out_sel_r;

  // Grant selection: the locked channel only, or the first valid channel at or after ptr.
  always_comb begin
    gidx_s   = {SW{1'b0}};
    gvalid_s = 1'b0;
    cand_s   = {SW{1'b0}};
    case (state_r)
      LOCKED: begin
        gidx_s   = lock_ch_r;
        gvalid_s = bus.in_valid[lock_ch_r];
      end
      ARB: begin
        // Walk the priority order backwards so the earliest valid candidate is written last.
        for (int k = N - 1; k >= 0; k--) begin
          cand_s   = SW'((int'(ptr_r) + k) % N);
          gidx_s   = bus.in_valid[cand_s] ? cand_s : gidx_s;
          gvalid_s = gvalid_s | bus.in_valid[cand_s];
        end
      end
      default: begin
        gidx_s   = {SW{1'b0}};
        gvalid_s = 1'b0;
      end
    endcase
  end

  // Data/last of the granted channel, muxed with constant slice indices.
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    sel_last_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      sel_data_s = (gidx_s == SW'(i)) ? bus.in_data[i*WIDTH +: WIDTH] : sel_data_s;
      sel_last_s = (gidx_s == SW'(i)) ? bus.in_last[i] : sel_last_s;
    end
  end

  // Arbiter next state: a transfer either closes the packet (advance ptr) or opens a lock.
  always_comb begin
    state_nx_s   = state_r;
    ptr_nx_s     = ptr_r;
    lock_ch_nx_s = lock_ch_r;
    if (xfer_s) begin
      if (sel_last_s || (LOCK_PKT == 1'b0)) begin
        state_nx_s = ARB;
        ptr_nx_s   = (gidx_s == SW'(N - 1)) ? {SW{1'b0}} : gidx_s + SW'(1);
      end else begin
        state_nx_s   = LOCKED;
        lock_ch_nx_s = gidx_s;
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ARB;
      ptr_r     <= {SW{1'b0}};
      lock_ch_r <= {SW{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      ptr_r     <= ptr_nx_s;
      lock_ch_r <= lock_ch_nx_s;
    end
  end

  // Output slot: payload only changes on a transfer so it stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_last_r  <= 1'b0;
      out_sel_r   <= {SW{1'b0}};
    end else if (load_en_s) begin
      out_valid_r <= xfer_s;
      if (xfer_s) begin
        out_data_r <= sel_data_s;
        out_last_r <= sel_last_s;
        out_sel_r  <= gidx_s;
      end
    end
  end
endmodule
